// File: rtl/cam_table_mgr.sv
// Table manager in front of a CAM: serialises insert/delete requests, tracks occupancy
// in a bitmap, and yields the compare port to the datapath lookup whenever it is active.
module cam_table_mgr #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    input  logic                  lkp_valid,
    input  logic [DATA_WIDTH-1:0] lkp_key,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  table_full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_EXISTS   = 2'b01;
    localparam logic [1:0] ST_FULL     = 2'b10;
    localparam logic [1:0] ST_NOTFOUND = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_CHK, S_WR, S_RSP} state_t;

    state_t                state_q, state_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [DEPTH-1:0]      bitmap_q, bitmap_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [1:0]            status_q, status_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] free_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            key_q    <= '0;
            target_q <= '0;
            bitmap_q <= '0;
            count_q  <= '0;
            status_q <= ST_OK;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            target_q <= target_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            status_q <= status_d;
            addr_q   <= addr_d;
        end
    end

    // Descending scan so the last assignment leaves the lowest free index.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!bitmap_q[i]) free_idx = i[ADDR_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        target_d = target_q;
        bitmap_d = bitmap_q;
        count_d  = count_q;
        status_d = status_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    key_d   = req_key;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (!lkp_valid) state_d = S_CHK;
            end
            S_CHK: begin
                if (!op_q) begin
                    if (cam_match) begin
                        status_d = ST_EXISTS;
                        addr_d   = cam_match_addr;
                        state_d  = S_RSP;
                    end else if (table_full) begin
                        status_d = ST_FULL;
                        addr_d   = '0;
                        state_d  = S_RSP;
                    end else begin
                        target_d = free_idx;
                        state_d  = S_WR;
                    end
                end else if (cam_match) begin
                    target_d = cam_match_addr;
                    state_d  = S_WR;
                end else begin
                    status_d = ST_NOTFOUND;
                    addr_d   = '0;
                    state_d  = S_RSP;
                end
            end
            S_WR: begin
                if (!cam_write_busy) begin
                    // Count follows the bitmap bit so it can neither overflow nor underflow.
                    if (op_q && bitmap_q[target_q])       count_d = count_q - CNT_ONE;
                    else if (!op_q && !bitmap_q[target_q]) count_d = count_q + CNT_ONE;
                    bitmap_d[target_q] = ~op_q;
                    status_d = ST_OK;
                    addr_d   = target_q;
                    state_d  = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready        = (state_q == S_IDLE);
    assign rsp_valid        = (state_q == S_RSP);
    assign rsp_status       = status_q;
    assign rsp_addr         = addr_q;
    assign cam_compare_data = lkp_valid ? lkp_key : key_q;
    assign cam_write_enable = (state_q == S_WR) && !cam_write_busy;
    assign cam_write_addr   = (state_q == S_WR) ? target_q : '0;
    assign cam_write_data   = (state_q == S_WR) ? key_q : '0;
    assign cam_write_delete = (state_q == S_WR) && op_q;
    assign entry_count      = count_q;
    // The count never exceeds DEPTH, so its MSB alone means "full".
    assign table_full       = count_q[ADDR_WIDTH];

endmodule

// File: doc/cam_table_mgr.md
CAM_TABLE_MGR -- requirements
Module: cam_table_mgr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: key width; SHALL equal the CAM's DATA_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: CAM address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have the request port: req_valid in 1 request present; req_ready out 1 request accepted; req_op in 1 (0 insert, 1 delete); req_key in DATA_WIDTH key.
REQ-005 SHALL have the response port: rsp_valid out 1; rsp_ready in 1; rsp_status out 2 (00 OK, 01 EXISTS, 10 FULL, 11 NOTFOUND); rsp_addr out ADDR_WIDTH entry index.
REQ-006 SHALL have the datapath lookup port: lkp_valid in 1 lookup this cycle; lkp_key in DATA_WIDTH key.
REQ-007 SHALL have the CAM write port: cam_write_addr out ADDR_WIDTH; cam_write_data out DATA_WIDTH; cam_write_delete out 1; cam_write_enable out 1; cam_write_busy in 1.
REQ-008 SHALL have the CAM compare port: cam_compare_data out DATA_WIDTH; cam_match in 1; cam_match_addr in ADDR_WIDTH.
REQ-009 SHALL have the status outputs: entry_count out ADDR_WIDTH+1 valid entries; table_full out 1 (entry_count == DEPTH).

Function
REQ-010 SHALL assume one-cycle CAM compare latency: cam_match/cam_match_addr valid the cycle after cam_compare_data is presented.
REQ-011 SHALL drive cam_compare_data = lkp_key whenever lkp_valid=1 (datapath has strict priority), otherwise = the latched request key.
REQ-012 SHALL implement FSM IDLE, CMP, CHK, WR, RSP; only one request is in flight at a time.
REQ-013 IDLE: req_ready=1; on req_valid, SHALL latch req_op/req_key and go to CMP.
REQ-014 CMP: SHALL stay in CMP while lkp_valid=1; when lkp_valid=0, the latched key is on the compare port and the FSM SHALL go to CHK next cycle.
REQ-015 CHK insert: on cam_match, status EXISTS, rsp_addr=cam_match_addr, go to RSP; else if table_full, status FULL, rsp_addr=0, go to RSP; else target = lowest free index in the occupancy bitmap, go to WR.
REQ-016 CHK delete: on cam_match, target = cam_match_addr, go to WR; else status NOTFOUND, rsp_addr=0, go to RSP.
REQ-017 WR: SHALL hold cam_write_enable=0 while cam_write_busy=1.
REQ-018 WR: otherwise SHALL assert cam_write_enable for exactly one cycle with cam_write_addr=target, cam_write_data=latched key, cam_write_delete=op.
REQ-019 In the cycle of that write, SHALL set (insert) or clear (delete) bitmap[target] and increment/decrement entry_count, then go to RSP with status OK, rsp_addr=target.
REQ-020 RSP: SHALL hold rsp_valid=1 with stable status/addr until rsp_ready=1; on that handshake cycle SHALL go to IDLE.
REQ-021 req_ready SHALL be 0 in every state except IDLE; a new request SHALL NOT be accepted in the RSP handshake cycle.
REQ-022 entry_count SHALL never exceed DEPTH nor underflow 0; insert at DEPTH-1 entries SHALL succeed, and the next insert SHALL return FULL.
REQ-023 Best-case latency from req accept to rsp_valid SHALL be 4 cycles: IDLE to CMP to CHK to WR to RSP for writes; 3 cycles for EXISTS/FULL/NOTFOUND.
REQ-024 cam_write_enable SHALL be 0 in all states other than WR.

Reset
REQ-025 On rst (asynchronous), SHALL force state IDLE, bitmap all-zero, entry_count=0, table_full=0, rsp_valid=0, rsp_status=00, rsp_addr=0, and cam_write_enable/cam_write_delete/cam_write_addr/cam_write_data=0.
REQ-026 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst asserted mid-request SHALL abort the request with no response issued; the CAM SHALL be reset by the same rst so that bitmap and CAM contents agree.

Verification
REQ-028 Insert keys 0xA, 0xB into an empty table -> OK at addr 0 then 1; entry_count=2; each write is a single cam_write_enable pulse with delete=0.
REQ-029 Insert 0xA again -> EXISTS, addr 0, no write pulse; delete 0xC -> NOTFOUND, addr 0, no write pulse.
REQ-030 Delete 0xA, then insert 0xD -> delete writes addr 0 with delete=1; insert reuses addr 0; entry_count stays 2.
REQ-031 Fill all 32 entries, then one more insert -> FULL; table_full=1; entry_count=32.
REQ-032 Hold lkp_valid=1 for 5 cycles during CMP -> cam_compare_data=lkp_key throughout and FSM stalls; response is delayed exactly 5 cycles. Hold cam_write_busy 3 cycles in WR -> write pulse delayed 3 cycles.
REQ-033 Assert rst while in WR or RSP -> rsp_valid=0 immediately; entry_count=0; next insert returns addr 0.
